// File: rtl/sram_bus_arbiter.sv
// Two-requester arbiter (instruction fetch / data) sharing one SRAM-like bus port.
// One transaction outstanding; data has priority, with a starvation guard for fetch.
module sram_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  inst_req,
  input  logic                  inst_wr,
  input  logic [1:0]            inst_size,
  input  logic [ADDR_W-1:0]     inst_addr,
  input  logic [DATA_W/8-1:0]   inst_wstrb,
  input  logic [DATA_W-1:0]     inst_wdata,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,

  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,

  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [1:0]            bus_size,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_W-1:0]     bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                state_q;
  logic                  owner_q;
  logic [2:0]            starve_cnt_q, starve_cnt_d;
  logic                  hold_wr_q;
  logic [1:0]            hold_size_q;
  logic [ADDR_W-1:0]     hold_addr_q;
  logic [DATA_W/8-1:0]   hold_wstrb_q;
  logic [DATA_W-1:0]     hold_wdata_q;

  logic grant_data, grant_inst, complete;

  // Fetch wins a contested grant only once data has won four times in a row.
  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (!reset && state_q == IDLE) begin
      grant_data = data_req && !(inst_req && starve_cnt_q == 3'd4);
      grant_inst = inst_req && !grant_data;
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    if (grant_data && inst_req)
      starve_cnt_d = (starve_cnt_q == 3'd4) ? 3'd4 : starve_cnt_q + 3'd1;
  end

  assign complete = !reset &&
                    ((state_q == REQ  && bus_addr_ok && bus_data_ok) ||
                     (state_q == RESP && bus_data_ok));

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = complete && !owner_q;
  assign data_data_ok = complete &&  owner_q;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  assign bus_req   = !reset && state_q == REQ;
  assign bus_wr    = hold_wr_q;
  assign bus_size  = hold_size_q;
  assign bus_addr  = hold_addr_q;
  assign bus_wstrb = hold_wstrb_q;
  assign bus_wdata = hold_wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_cnt_q <= '0;
      hold_wr_q    <= 1'b0;
      hold_size_q  <= '0;
      hold_addr_q  <= '0;
      hold_wstrb_q <= '0;
      hold_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_data || grant_inst) begin
            owner_q      <= grant_data;
            starve_cnt_q <= starve_cnt_d;
            hold_wr_q    <= grant_data ? data_wr    : inst_wr;
            hold_size_q  <= grant_data ? data_size  : inst_size;
            hold_addr_q  <= grant_data ? data_addr  : inst_addr;
            hold_wstrb_q <= grant_data ? data_wstrb : inst_wstrb;
            hold_wdata_q <= grant_data ? data_wdata : inst_wdata;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (bus_addr_ok)
            state_q <= bus_data_ok ? IDLE : RESP;
        end
        RESP: begin
          if (bus_data_ok)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: inputs driven 1ns after posedge,
// outputs checked on the following negedge.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int unsigned checks = 0;
  int unsigned errors = 0;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic oks(input string tag, input logic ia, input logic da,
                     input logic id, input logic dd, input logic br);
    @(negedge clk);
    chk({tag, ".inst_addr_ok"}, inst_addr_ok, ia);
    chk({tag, ".data_addr_ok"}, data_addr_ok, da);
    chk({tag, ".inst_data_ok"}, inst_data_ok, id);
    chk({tag, ".data_data_ok"}, data_data_ok, dd);
    chk({tag, ".bus_req"},      bus_req,      br);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 2; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2; data_addr = '0; data_wstrb = '0; data_wdata = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;

    // Reset: requests and bus responses present, all handshakes forced low
    step();
    inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h5a5a_0001;
    oks("reset", 0, 0, 0, 0, 0);
    chk("reset.inst_rdata", inst_rdata, 32'h5a5a_0001);
    chk("reset.data_rdata", data_rdata, 32'h5a5a_0001);
    step();
    oks("reset2", 0, 0, 0, 0, 0);
    chk("reset.bus_addr", bus_addr, 32'h0);

    // Single read from fetch
    step();
    reset = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
    inst_req = 1; inst_wr = 0; inst_addr = 32'h1c00_0000;
    oks("rd.c0", 1, 0, 0, 0, 0);
    step();
    inst_req = 0; inst_addr = 32'h0; bus_addr_ok = 1;
    oks("rd.c1", 0, 0, 0, 0, 1);
    chk("rd.bus_addr", bus_addr, 32'h1c00_0000);
    chk("rd.bus_wr", bus_wr, 1'b0);
    step();
    bus_addr_ok = 0;
    oks("rd.c2", 0, 0, 0, 0, 0);
    step();
    bus_data_ok = 1; bus_rdata = 32'h0280_0c0c;
    oks("rd.c3", 0, 0, 1, 0, 0);
    chk("rd.inst_rdata", inst_rdata, 32'h0280_0c0c);
    step();
    bus_data_ok = 0;
    oks("rd.c4", 0, 0, 0, 0, 0);

    // Simultaneous requests: data write first, then fetch
    step();
    inst_req = 1; inst_addr = 32'h0000_2000;
    data_req = 1; data_wr = 1; data_addr = 32'h100; data_wstrb = 4'b0011; data_wdata = 32'h1234;
    oks("sim.grant", 0, 1, 0, 0, 0);
    step();
    data_req = 0; data_wr = 0; data_addr = '0; data_wstrb = '0; data_wdata = '0;
    bus_addr_ok = 1;
    oks("sim.req", 0, 0, 0, 0, 1);
    chk("sim.bus_wr", bus_wr, 1'b1);
    chk("sim.bus_addr", bus_addr, 32'h100);
    chk("sim.bus_wstrb", bus_wstrb, 4'b0011);
    chk("sim.bus_wdata", bus_wdata, 32'h1234);
    step();
    bus_addr_ok = 0; bus_data_ok = 1;
    oks("sim.resp", 0, 0, 0, 1, 0);
    step();
    bus_data_ok = 0;
    oks("sim.inst_grant", 1, 0, 0, 0, 0);

    // Same-cycle completion, next grant in the following cycle
    step();
    inst_req = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hdead_beef;
    oks("same.done", 0, 0, 1, 0, 1);
    chk("same.bus_addr", bus_addr, 32'h2000);
    chk("same.inst_rdata", inst_rdata, 32'hdead_beef);
    step();
    bus_addr_ok = 0; bus_data_ok = 0;
    data_req = 1; data_wr = 0; data_addr = 32'h200;
    oks("same.next_grant", 0, 1, 0, 0, 0);
    step();
    data_req = 0; bus_addr_ok = 1;
    oks("rst.req", 0, 0, 0, 0, 1);
    chk("rst.bus_addr", bus_addr, 32'h200);
    step();
    bus_addr_ok = 0;
    oks("rst.in_resp", 0, 0, 0, 0, 0);

    // Reset while in RESP: response during and after reset is dropped
    step();
    reset = 1; bus_data_ok = 1; inst_req = 1; data_req = 1;
    oks("rst.during", 0, 0, 0, 0, 0);
    step();
    reset = 0; inst_req = 0; data_req = 0; bus_data_ok = 1;
    oks("rst.stray", 0, 0, 0, 0, 0);
    chk("rst.hold_cleared", bus_addr, 32'h0);
    step();
    bus_data_ok = 0; data_req = 1; data_addr = 32'h300;
    oks("rst.after_grant", 0, 1, 0, 0, 0);
    step();
    data_req = 0; bus_addr_ok = 1;
    oks("rst.after_req", 0, 0, 0, 0, 1);
    chk("rst.after_addr", bus_addr, 32'h300);
    step();
    bus_addr_ok = 0; bus_data_ok = 1;
    oks("rst.after_resp", 0, 0, 0, 1, 0);

    // Stalled bus: held request stays stable, nobody else is accepted
    step();
    bus_data_ok = 0;
    inst_req = 1; inst_wr = 1; inst_size = 1; inst_addr = 32'h4444;
    inst_wstrb = 4'hf; inst_wdata = 32'hcafe_f00d;
    oks("stall.grant", 1, 0, 0, 0, 0);
    step();
    inst_wr = 0; inst_size = 0; inst_addr = 32'h9999; inst_wstrb = 4'h1; inst_wdata = 32'h1;
    data_req = 1; data_wr = 0; data_addr = 32'h8888; data_wstrb = 4'h2;
    for (int i = 0; i < 10; i++) begin
      oks("stall.cyc", 0, 0, 0, 0, 1);
      chk("stall.bus_wr", bus_wr, 1'b1);
      chk("stall.bus_size", bus_size, 2'd1);
      chk("stall.bus_addr", bus_addr, 32'h4444);
      chk("stall.bus_wstrb", bus_wstrb, 4'hf);
      chk("stall.bus_wdata", bus_wdata, 32'hcafe_f00d);
      step();
    end
    inst_req = 0; data_req = 0; inst_size = 2; data_size = 2; inst_wr = 0;
    bus_addr_ok = 1; bus_data_ok = 1;
    oks("stall.release", 0, 0, 1, 0, 1);

    // Starvation guard: both requesting continuously
    step();
    bus_addr_ok = 0; bus_data_ok = 0;
    inst_req = 1; data_req = 1;
    for (int i = 0; i < 10; i++) begin
      logic exp_inst;
      exp_inst = (i == 4 || i == 9);
      oks("starve.grant", exp_inst, !exp_inst, 0, 0, 0);
      step();
      bus_addr_ok = 1; bus_data_ok = 1;
      oks("starve.done", 0, 0, exp_inst, !exp_inst, 1);
      step();
      bus_addr_ok = 0; bus_data_ok = 0;
    end
    inst_req = 0; data_req = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares one SRAM-like memory port between the instruction-fetch requester and the data (EX/MEM load/store) requester. Sits between the pipeline stages and the memory bus.
- One transaction outstanding at a time.
- Requests are captured into a holding register the cycle they are granted, then replayed on the bus.
- Read data is routed back to whichever requester owns the transaction.
- Data has fixed priority over instruction, with a starvation guard so fetch always makes progress.

## Interface
Parameters:
- ADDR_W, 32, address width of all three ports
- DATA_W, 32, data width of all three ports; wstrb width is DATA_W/8

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- inst_req / data_req  in  1  requester presents a transaction
- inst_wr / data_wr  in  1  1 = write, 0 = read
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
- inst_addr / data_addr  in  ADDR_W  byte address
- inst_wstrb / data_wstrb  in  DATA_W/8  byte enables (writes)
- inst_wdata / data_wdata  in  DATA_W  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  transaction complete; rdata valid for reads
- inst_rdata / data_rdata  out  DATA_W  read data, both equal to bus_rdata
- bus_req  out  1  bus request valid
- bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata  out  as above  held request fields
- bus_addr_ok  in  1  bus accepted request
- bus_data_ok  in  1  bus response valid
- bus_rdata  in  DATA_W  bus read data

## Operation
- FSM states: IDLE, REQ, RESP. Registers:
  - hold_wr, hold_size, hold_addr, hold_wstrb, hold_wdata
  - owner (0 = inst, 1 = data)
  - starve_cnt (3 bits)
- IDLE, grant selection:
  - data_req only → grant data.
  - inst_req only → grant inst.
  - Both → grant data, unless starve_cnt == 4, then grant inst.
- IDLE, on grant:
  - Granted requester's addr_ok = 1 (combinational, same cycle).
  - Capture its fields into hold_*; set owner; go to REQ.
  - Non-granted requester's addr_ok = 0; it must keep its request asserted.
- starve_cnt update (IDLE grant cycles only):
  - Data granted while inst_req = 1 → increment.
  - Inst granted → clear.
  - Data granted with inst_req = 0 → clear.
  - Saturates at 4.
- REQ:
  - bus_req = 1; bus_* = hold_*.
  - On bus_addr_ok → RESP.
  - If bus_data_ok is also 1 that cycle → complete immediately (see RESP) and go to IDLE.
- RESP:
  - bus_req = 0.
  - On bus_data_ok: assert owner's *_data_ok (combinational), go to IDLE.
- No new grant in REQ or RESP. A request arriving then waits until IDLE.
- bus_data_ok while in IDLE is ignored; no data_ok is generated.
- bus_addr_ok while bus_req = 0 is ignored.
- bus_* fields equal hold_* in all states. Only bus_req qualifies them.

## Timing
- Reset: while reset = 1 the next state is IDLE, and starve_cnt, owner and hold_* clear to 0.
- Outputs while reset = 1:
  - bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok are all forced 0.
  - *_rdata follow bus_rdata.
- Reset mid-transaction abandons it. No data_ok is produced for it.
- Minimum latency, with bus_addr_ok and bus_data_ok each arriving the cycle they are first possible:
  - Cycle 0: requester addr_ok.
  - Cycle 1: bus_req with bus_addr_ok.
  - Cycle 2: bus_data_ok and requester data_ok.
- The next grant is possible in cycle 3.
- With bus_addr_ok and bus_data_ok in the same cycle (cycle 1), completion is in cycle 1 and the next grant in cycle 2.
- Handshake rule: a transfer occurs only on req & addr_ok in the same cycle. Requester inputs are sampled only in that cycle.
- Back-to-back completion throughput is at most one transaction per 2 cycles.

## Test plan
- Single read:
  - Stimulus: inst_req at addr 0x1c000000 in cycle 0; bus_addr_ok in cycle 1; bus_data_ok with rdata 0x02800c0c in cycle 3.
  - Required: inst_addr_ok in cycle 0; bus_req in cycle 1 only; inst_data_ok and inst_rdata = 0x02800c0c in cycle 3; data_data_ok never asserts.
- Simultaneous requests:
  - Stimulus: inst_req and data write (addr 0x100, wstrb 4'b0011, wdata 0x1234) in the same cycle.
  - Required: data granted first with bus_wr = 1, bus_addr = 0x100, bus_wstrb = 0011. Inst is granted at the first IDLE after data_data_ok.
- Starvation guard:
  - Stimulus: inst_req and data_req held high continuously.
  - Required: grant order is D, D, D, D, I, D, D, D, D, I.
- Same-cycle completion:
  - Stimulus: bus_addr_ok and bus_data_ok asserted together in REQ.
  - Required: owner data_ok in that cycle; next grant accepted the following cycle.
- Reset mid-transaction:
  - Stimulus: reset pulsed while in RESP; a stray bus_data_ok arrives in IDLE after reset.
  - Required: all ok/req outputs are 0 during reset; the stray bus_data_ok produces no data_ok; the next request proceeds normally.
- Stalled bus:
  - Stimulus: bus_addr_ok held 0 for 10 cycles.
  - Required: bus_req and all bus_* fields stable for all 10 cycles; no addr_ok to either requester.
